nasti_lite_reg_slave: RTL and testbench

- NASTI-Lite responder that terminates the lite side of a NASTI/NASTI-Lite bridge into a bank of NREG software-visible registers.
- Accepts independent read and write transactions and returns B/R responses that echo the request ID and user fields.
- Exposes all register contents and per-register write strobes to surrounding peripheral logic.
- Serves as the standard endpoint for control/status blocks hanging off the lite bus.

---
 rtl/nasti_lite_reg_pkg.sv | 36 +++
 rtl/nasti_lite_reg_slot.sv | 43 ++++
 rtl/nasti_lite_reg_slave.sv | 208 ++++++++++++++++++++
 tb/tb_nasti_lite_reg_slave.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nasti_lite_reg_pkg.sv
// ============================================================================
// Module   : nasti_lite_reg_pkg
// Brief    : Response codes and helper functions for the NASTI-Lite register slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nasti_lite_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Byte-lane merge sized for the widest supported bus; callers cast to their width.
  function automatic logic [63:0] strb_merge(input logic [63:0] old_word,
                                             input logic [63:0] new_word,
                                             input logic [7:0]  strb);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) begin
      m[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/nasti_lite_reg_slot.sv
// ============================================================================
// Module   : nasti_lite_reg_slot
// Brief    : One-entry valid/ready holding register, emptied by an external clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nasti_lite_reg_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_clear,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  assign o_ready = !r_full && !rst;
  assign o_full  = r_full;
  assign o_data  = r_data;

  // Clear is only raised while full, so it never collides with an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_valid && o_ready) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/nasti_lite_reg_slave.sv
// ============================================================================
// Module   : nasti_lite_reg_slave
// Brief    : NASTI-Lite responder backed by NREG software-visible registers.
//            Define NASTI_LITE_REG_DECERR_EN to answer out-of-range with DECERR.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nasti_lite_reg_slave
  import nasti_lite_reg_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int NREG       = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ID_WIDTH-1:0]        lite_aw_id,
  input  logic [ADDR_WIDTH-1:0]      lite_aw_addr,
  input  logic [2:0]                 lite_aw_prot,
  input  logic [3:0]                 lite_aw_qos,
  input  logic [3:0]                 lite_aw_region,
  input  logic [USER_WIDTH-1:0]      lite_aw_user,
  input  logic                       lite_aw_valid,
  output logic                       lite_aw_ready,
  input  logic [DATA_WIDTH-1:0]      lite_w_data,
  input  logic [DATA_WIDTH/8-1:0]    lite_w_strb,
  input  logic [USER_WIDTH-1:0]      lite_w_user,
  input  logic                       lite_w_valid,
  output logic                       lite_w_ready,
  output logic [ID_WIDTH-1:0]        lite_b_id,
  output logic [1:0]                 lite_b_resp,
  output logic [USER_WIDTH-1:0]      lite_b_user,
  output logic                       lite_b_valid,
  input  logic                       lite_b_ready,
  input  logic [ID_WIDTH-1:0]        lite_ar_id,
  input  logic [ADDR_WIDTH-1:0]      lite_ar_addr,
  input  logic [2:0]                 lite_ar_prot,
  input  logic [3:0]                 lite_ar_qos,
  input  logic [3:0]                 lite_ar_region,
  input  logic [USER_WIDTH-1:0]      lite_ar_user,
  input  logic                       lite_ar_valid,
  output logic                       lite_ar_ready,
  output logic [ID_WIDTH-1:0]        lite_r_id,
  output logic [DATA_WIDTH-1:0]      lite_r_data,
  output logic [1:0]                 lite_r_resp,
  output logic [USER_WIDTH-1:0]      lite_r_user,
  output logic                       lite_r_valid,
  input  logic                       lite_r_ready,
  output logic [NREG*DATA_WIDTH-1:0] reg_q,
  output logic [NREG-1:0]            reg_wr
);

  localparam int c_shift = clog2(DATA_WIDTH / 8);
  localparam int c_idxw  = ADDR_WIDTH - c_shift;
  localparam int c_strbw = DATA_WIDTH / 8;
  localparam int c_aww   = ID_WIDTH + USER_WIDTH + c_idxw;
  localparam int c_ww    = DATA_WIDTH + c_strbw;
  localparam logic [c_idxw:0] c_nreg = (c_idxw + 1)'(NREG);
`ifdef NASTI_LITE_REG_DECERR_EN
  localparam logic [1:0] c_err = RESP_DECERR;
`else
  localparam logic [1:0] c_err = RESP_SLVERR;
`endif

  logic [c_aww-1:0]      w_aw_in, w_aw_q;
  logic [c_ww-1:0]       w_w_in, w_w_q;
  logic                  w_aw_full, w_w_full, w_commit, w_wr_hit;
  logic [ID_WIDTH-1:0]   w_aw_id;
  logic [USER_WIDTH-1:0] w_aw_user;
  logic [c_idxw-1:0]     w_aw_idx, w_ar_idx;
  logic [DATA_WIDTH-1:0] w_wdata, w_rd_data;
  logic [c_strbw-1:0]    w_wstrb;
  logic                  w_ar_hit, w_unused;

  logic                  r_b_valid;
  logic [ID_WIDTH-1:0]   r_b_id;
  logic [USER_WIDTH-1:0] r_b_user;
  logic [1:0]            r_b_resp;
  logic                  r_r_valid;
  logic [ID_WIDTH-1:0]   r_r_id;
  logic [USER_WIDTH-1:0] r_r_user;
  logic [1:0]            r_r_resp;
  logic [DATA_WIDTH-1:0] r_r_data;

  assign w_unused = ^{lite_aw_prot, lite_aw_qos, lite_aw_region, lite_w_user,
                      lite_ar_prot, lite_ar_qos, lite_ar_region,
                      lite_aw_addr[c_shift-1:0], lite_ar_addr[c_shift-1:0]};

  // Only the word index is kept; byte offset bits carry no meaning here.
  assign w_aw_in = {lite_aw_id, lite_aw_user, lite_aw_addr[ADDR_WIDTH-1:c_shift]};
  assign w_w_in  = {lite_w_data, lite_w_strb};
  assign {w_aw_id, w_aw_user, w_aw_idx} = w_aw_q;
  assign {w_wdata, w_wstrb} = w_w_q;

  assign w_commit = w_aw_full && w_w_full && !r_b_valid;
  assign w_wr_hit = ({1'b0, w_aw_idx} < c_nreg);

  nasti_lite_reg_slot #(.WIDTH(c_aww)) u_aw_slot (
    .clk     (clk),
    .rst     (rst),
    .i_valid (lite_aw_valid),
    .o_ready (lite_aw_ready),
    .i_data  (w_aw_in),
    .i_clear (w_commit),
    .o_full  (w_aw_full),
    .o_data  (w_aw_q)
  );

  nasti_lite_reg_slot #(.WIDTH(c_ww)) u_w_slot (
    .clk     (clk),
    .rst     (rst),
    .i_valid (lite_w_valid),
    .o_ready (lite_w_ready),
    .i_data  (w_w_in),
    .i_clear (w_commit),
    .o_full  (w_w_full),
    .o_data  (w_w_q)
  );

  generate
    for (genvar k = 0; k < NREG; k++) begin : g_reg
      logic [DATA_WIDTH-1:0] r_val;
      logic                  r_wr;
      logic                  w_sel;

      assign w_sel = w_commit && (w_aw_idx == c_idxw'(k));

      always_ff @(posedge clk) begin
        if (rst) begin
          r_val <= RESET_VAL;
          r_wr  <= 1'b0;
        end else begin
          r_wr <= w_sel;
          if (w_sel) begin
            r_val <= DATA_WIDTH'(strb_merge(64'(r_val), 64'(w_wdata), 8'(w_wstrb)));
          end
        end
      end

      assign reg_q[k*DATA_WIDTH +: DATA_WIDTH] = r_val;
      assign reg_wr[k] = r_wr;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b_valid <= 1'b0;
      r_b_id    <= '0;
      r_b_user  <= '0;
      r_b_resp  <= '0;
    end else if (w_commit) begin
      r_b_valid <= 1'b1;
      r_b_id    <= w_aw_id;
      r_b_user  <= w_aw_user;
      r_b_resp  <= w_wr_hit ? RESP_OKAY : c_err;
    end else if (lite_b_ready) begin
      r_b_valid <= 1'b0;
    end
  end

  assign lite_b_valid = r_b_valid;
  assign lite_b_id    = r_b_id;
  assign lite_b_user  = r_b_user;
  assign lite_b_resp  = r_b_resp;

  assign w_ar_idx      = lite_ar_addr[ADDR_WIDTH-1:c_shift];
  assign w_ar_hit      = ({1'b0, w_ar_idx} < c_nreg);
  assign lite_ar_ready = (!r_r_valid || lite_r_ready) && !rst;

  // Reads sample reg_q before any same-cycle commit lands, returning the old value.
  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < NREG; k++) begin
      if (w_ar_idx == c_idxw'(k)) w_rd_data = reg_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_r_valid <= 1'b0;
      r_r_id    <= '0;
      r_r_user  <= '0;
      r_r_resp  <= '0;
      r_r_data  <= '0;
    end else if (lite_ar_valid && lite_ar_ready) begin
      r_r_valid <= 1'b1;
      r_r_id    <= lite_ar_id;
      r_r_user  <= lite_ar_user;
      r_r_resp  <= w_ar_hit ? RESP_OKAY : c_err;
      r_r_data  <= w_rd_data;
    end else if (lite_r_ready) begin
      r_r_valid <= 1'b0;
    end
  end

  assign lite_r_valid = r_r_valid;
  assign lite_r_id    = r_r_id;
  assign lite_r_user  = r_r_user;
  assign lite_r_resp  = r_r_resp;
  assign lite_r_data  = r_r_data;

endmodule

`default_nettype wire

// File: tb/tb_nasti_lite_reg_slave.sv
// ============================================================================
// Module   : tb_nasti_lite_reg_slave
// Brief    : Self-checking bench for nasti_lite_reg_slave (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nasti_lite_reg_slave;

  localparam int NREG = 8;
`ifdef NASTI_LITE_REG_DECERR_EN
  localparam logic [1:0] ERR = 2'b11;
`else
  localparam logic [1:0] ERR = 2'b10;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [0:0]  lite_aw_id = '0, lite_aw_user = '0, lite_w_user = '0;
  logic [7:0]  lite_aw_addr = '0, lite_ar_addr = '0;
  logic [2:0]  lite_aw_prot = '0, lite_ar_prot = '0;
  logic [3:0]  lite_aw_qos = '0, lite_aw_region = '0, lite_ar_qos = '0, lite_ar_region = '0;
  logic        lite_aw_valid = 1'b0, lite_w_valid = 1'b0, lite_b_ready = 1'b0;
  logic        lite_ar_valid = 1'b0, lite_r_ready = 1'b0;
  logic [31:0] lite_w_data = '0;
  logic [3:0]  lite_w_strb = '0;
  logic [0:0]  lite_ar_id = '0, lite_ar_user = '0;
  logic        lite_aw_ready, lite_w_ready, lite_b_valid, lite_ar_ready, lite_r_valid;
  logic [0:0]  lite_b_id, lite_b_user, lite_r_id, lite_r_user;
  logic [1:0]  lite_b_resp, lite_r_resp;
  logic [31:0] lite_r_data;
  logic [NREG*32-1:0] reg_q;
  logic [NREG-1:0]    reg_wr;

  nasti_lite_reg_slave #(
    .ID_WIDTH(1), .ADDR_WIDTH(8), .DATA_WIDTH(32), .USER_WIDTH(1), .NREG(NREG), .RESET_VAL(32'h0)
  ) dut (
    .clk(clk), .rst(rst),
    .lite_aw_id(lite_aw_id), .lite_aw_addr(lite_aw_addr), .lite_aw_prot(lite_aw_prot),
    .lite_aw_qos(lite_aw_qos), .lite_aw_region(lite_aw_region), .lite_aw_user(lite_aw_user),
    .lite_aw_valid(lite_aw_valid), .lite_aw_ready(lite_aw_ready),
    .lite_w_data(lite_w_data), .lite_w_strb(lite_w_strb), .lite_w_user(lite_w_user),
    .lite_w_valid(lite_w_valid), .lite_w_ready(lite_w_ready),
    .lite_b_id(lite_b_id), .lite_b_resp(lite_b_resp), .lite_b_user(lite_b_user),
    .lite_b_valid(lite_b_valid), .lite_b_ready(lite_b_ready),
    .lite_ar_id(lite_ar_id), .lite_ar_addr(lite_ar_addr), .lite_ar_prot(lite_ar_prot),
    .lite_ar_qos(lite_ar_qos), .lite_ar_region(lite_ar_region), .lite_ar_user(lite_ar_user),
    .lite_ar_valid(lite_ar_valid), .lite_ar_ready(lite_ar_ready),
    .lite_r_id(lite_r_id), .lite_r_data(lite_r_data), .lite_r_resp(lite_r_resp),
    .lite_r_user(lite_r_user), .lite_r_valid(lite_r_valid), .lite_r_ready(lite_r_ready),
    .reg_q(reg_q), .reg_wr(reg_wr)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  logic [31:0] mdl [NREG];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endfunction

  function automatic bit in_rng(input logic [7:0] a);
    return int'(a >> 2) < NREG;
  endfunction

  function automatic void mdl_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_rng(a)) begin
      for (int i = 0; i < 4; i++) begin
        if (s[i]) mdl[a >> 2][i*8 +: 8] = d[i*8 +: 8];
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int bdly, input logic id, input logic usr,
                          output logic [1:0] resp, output logic [NREG-1:0] wr_seen);
    bit aw_pend, w_pend, got, aw_f, w_f;
    int cyc, bw;
    aw_pend = 1; w_pend = 1; got = 0; cyc = 0; bw = 0; wr_seen = '0; resp = '0;
    while (!got && cyc < 60) begin
      lite_aw_valid = aw_pend && (cyc >= (lead > 0 ? lead : 0));
      lite_w_valid  = w_pend && (cyc >= (lead < 0 ? -lead : 0));
      lite_aw_addr = a; lite_aw_id = id; lite_aw_user = usr;
      lite_w_data = d; lite_w_strb = s;
      lite_b_ready = (bw >= bdly);
      @(negedge clk);
      aw_f = lite_aw_valid && lite_aw_ready;
      w_f  = lite_w_valid && lite_w_ready;
      wr_seen |= reg_wr;
      if (lite_b_valid) begin
        if (lite_b_ready) begin
          got = 1;
          resp = lite_b_resp;
          chk("b_id", lite_b_id, id);
          chk("b_user", lite_b_user, usr);
        end
        bw++;
      end
      step();
      if (aw_f) aw_pend = 0;
      if (w_f) w_pend = 0;
      cyc++;
    end
    lite_aw_valid = 0; lite_w_valid = 0; lite_b_ready = 0;
    if (!got) chk("b_timeout", 0, 1);
  endtask

  task automatic do_read(input logic [7:0] a, input logic id, input logic usr, input int rdly,
                         output logic [31:0] data, output logic [1:0] resp);
    bit ar_pend, got, seen, ar_f;
    int cyc, wn;
    logic [31:0] first;
    ar_pend = 1; got = 0; seen = 0; cyc = 0; wn = 0; first = '0; data = '0; resp = '0;
    while (!got && cyc < 60) begin
      lite_ar_valid = ar_pend; lite_ar_addr = a; lite_ar_id = id; lite_ar_user = usr;
      lite_r_ready = (wn >= rdly);
      @(negedge clk);
      ar_f = lite_ar_valid && lite_ar_ready;
      if (lite_r_valid) begin
        if (seen) chk("r_stable", lite_r_data, first);
        else begin
          first = lite_r_data;
          seen = 1;
        end
        if (lite_r_ready) begin
          got = 1;
          data = lite_r_data;
          resp = lite_r_resp;
          chk("r_id", lite_r_id, id);
          chk("r_user", lite_r_user, usr);
        end
        wn++;
      end
      step();
      if (ar_f) ar_pend = 0;
      cyc++;
    end
    lite_ar_valid = 0; lite_r_ready = 0;
    if (!got) chk("r_timeout", 0, 1);
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    int          lead;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] val;
  } vec_t;

  initial begin
    vec_t tbl[12];
    logic [1:0]  rsp;
    logic [NREG-1:0] wrs;
    logic [31:0] rd;
    logic [31:0] q[$];
    bit acc, sel;

    tbl[0]  = '{1'b1, 8'h04,  0, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 8'h04,  3, 32'h000000AA, 4'h1, 2'b00, 32'hDEADBEAA};
    tbl[2]  = '{1'b0, 8'h04,  0, 32'h0,        4'h0, 2'b00, 32'hDEADBEAA};
    tbl[3]  = '{1'b1, 8'h40, -2, 32'h12345678, 4'hF, ERR,   32'h0};
    tbl[4]  = '{1'b0, 8'h40,  0, 32'h0,        4'h0, ERR,   32'h0};
    tbl[5]  = '{1'b1, 8'h0A,  1, 32'h12345678, 4'hC, 2'b00, 32'h12341111};
    tbl[6]  = '{1'b0, 8'h09,  0, 32'h0,        4'h0, 2'b00, 32'h12341111};
    tbl[7]  = '{1'b1, 8'h1C,  0, 32'hFFFFFFFF, 4'hF, 2'b00, 32'hFFFFFFFF};
    tbl[8]  = '{1'b0, 8'h1F,  0, 32'h0,        4'h0, 2'b00, 32'hFFFFFFFF};
    tbl[9]  = '{1'b1, 8'h20, -1, 32'h55555555, 4'hF, ERR,   32'h0};
    tbl[10] = '{1'b0, 8'h20,  0, 32'h0,        4'h0, ERR,   32'h0};
    tbl[11] = '{1'b0, 8'h0C,  0, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
    for (int k = 0; k < NREG; k++) mdl[k] = 32'h0;

    // Reset: everything quiet while rst is high, channels ready right after.
    step(); step();
    @(negedge clk);
    chk("rst_valid_ready", {lite_aw_ready, lite_w_ready, lite_ar_ready, lite_b_valid, lite_r_valid}, 0);
    chk("rst_reg_wr", reg_wr, 0);
    for (int k = 0; k < NREG; k++) chk("rst_reg_q", reg_q[k*32 +: 32], 32'h0);
    step();
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", {lite_aw_ready, lite_w_ready, lite_ar_ready}, 3'b111);
    chk("post_rst_valid", {lite_b_valid, lite_r_valid}, 2'b00);
    step();

    // Write latency: AW+W in cycle 0, b_valid / reg_wr / reg_q in cycle 2.
    lite_aw_valid = 1; lite_aw_addr = 8'h0C; lite_aw_id = 1; lite_aw_user = 1;
    lite_w_valid = 1; lite_w_data = 32'hCAFEF00D; lite_w_strb = 4'hF; lite_b_ready = 0;
    @(negedge clk);
    chk("lat_c0_ready", {lite_aw_ready, lite_w_ready}, 2'b11);
    step();
    lite_aw_valid = 0; lite_w_valid = 0;
    @(negedge clk);
    chk("lat_c1_bvalid", lite_b_valid, 0);
    chk("lat_c1_reg_wr", reg_wr, 0);
    step();
    lite_b_ready = 1;
    @(negedge clk);
    chk("lat_c2_bvalid", lite_b_valid, 1);
    chk("lat_c2_bid", {lite_b_id, lite_b_user, lite_b_resp}, 4'b1100);
    chk("lat_c2_reg_wr", reg_wr, 8'h08);
    chk("lat_c2_reg_q", reg_q[3*32 +: 32], 32'hCAFEF00D);
    step();
    lite_b_ready = 0;
    @(negedge clk);
    chk("lat_c3_bvalid", lite_b_valid, 0);
    chk("lat_c3_reg_wr", reg_wr, 0);
    mdl_write(8'h0C, 32'hCAFEF00D, 4'hF);
    step();

    // Read colliding with a commit to the same register sees the old value.
    lite_aw_valid = 1; lite_aw_addr = 8'h08; lite_aw_id = 0; lite_aw_user = 0;
    lite_w_valid = 1; lite_w_data = 32'h11111111; lite_w_strb = 4'hF; lite_b_ready = 1;
    @(negedge clk);
    step();
    lite_aw_valid = 0; lite_w_valid = 0;
    lite_ar_valid = 1; lite_ar_addr = 8'h08; lite_ar_id = 0; lite_ar_user = 0; lite_r_ready = 1;
    @(negedge clk);
    chk("coll_ar_ready", lite_ar_ready, 1);
    step();
    lite_ar_valid = 0;
    @(negedge clk);
    chk("coll_r_valid", lite_r_valid, 1);
    chk("coll_r_data_old", lite_r_data, 32'h0);
    chk("coll_b_valid", lite_b_valid, 1);
    chk("coll_reg_q", reg_q[2*32 +: 32], 32'h11111111);
    step();
    lite_b_ready = 0; lite_r_ready = 0;
    mdl_write(8'h08, 32'h11111111, 4'hF);
    do_read(8'h08, 1'b0, 1'b0, 0, rd, rsp);
    chk("coll_r_data_new", rd, 32'h11111111);

    // B backpressure: second AW/W is held, not committed, until B completes.
    lite_aw_valid = 1; lite_aw_addr = 8'h10; lite_w_valid = 1;
    lite_w_data = 32'h1; lite_w_strb = 4'hF; lite_b_ready = 0;
    @(negedge clk);
    step();
    lite_w_data = 32'h2;
    acc = 0;
    for (int i = 0; i < 6 && !acc; i++) begin
      @(negedge clk);
      if (lite_aw_ready && lite_w_ready) acc = 1;
      step();
    end
    lite_aw_valid = 0; lite_w_valid = 0;
    chk("bp_second_accepted", acc, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_hold_bvalid", lite_b_valid, 1);
      chk("bp_hold_ready", {lite_aw_ready, lite_w_ready}, 2'b00);
      chk("bp_hold_reg_q", reg_q[4*32 +: 32], 32'h1);
      chk("bp_hold_reg_wr", reg_wr, 0);
      step();
    end
    lite_b_ready = 1;
    @(negedge clk);
    step();
    lite_b_ready = 0;
    @(negedge clk);
    chk("bp_commit_bvalid", lite_b_valid, 0);
    step();
    @(negedge clk);
    chk("bp_second_bvalid", lite_b_valid, 1);
    chk("bp_second_reg_q", reg_q[4*32 +: 32], 32'h2);
    chk("bp_second_reg_wr", reg_wr, 8'h10);
    step();
    lite_b_ready = 1;
    @(negedge clk);
    step();
    lite_b_ready = 0;
    mdl_write(8'h10, 32'h1, 4'hF);
    mdl_write(8'h10, 32'h2, 4'hF);

    // Directed vector table.
    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].lead, 1, 1'b0, 1'b1, rsp, wrs);
        mdl_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
        chk("tbl_b_resp", rsp, tbl[i].resp);
        chk("tbl_reg_wr", wrs, (tbl[i].resp == 2'b00) ? 8'(1 << (tbl[i].addr >> 2)) : 8'h00);
        if (tbl[i].resp == 2'b00) chk("tbl_reg_q", reg_q[int'(tbl[i].addr >> 2)*32 +: 32], tbl[i].val);
      end else begin
        do_read(tbl[i].addr, 1'b1, 1'b0, 0, rd, rsp);
        chk("tbl_r_resp", rsp, tbl[i].resp);
        chk("tbl_r_data", rd, tbl[i].val);
      end
    end

    // Streaming reads, first at full rate, then with r_ready toggling.
    q.delete();
    sel = 0;
    for (int i = 0; i < 20; i++) begin
      lite_ar_valid = 1; lite_ar_addr = sel ? 8'h0C : 8'h04; lite_ar_id = 0; lite_ar_user = 0;
      lite_r_ready = (i < 8) ? 1'b1 : ((i % 2) == 1);
      @(negedge clk);
      chk("strm_ar_ready", lite_ar_ready, (q.size() == 0) || lite_r_ready);
      chk("strm_r_valid", lite_r_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("strm_r_data", lite_r_data, q[0]);
        chk("strm_r_resp", lite_r_resp, 2'b00);
        if (lite_r_ready) void'(q.pop_front());
      end
      if (lite_ar_ready) begin
        q.push_back(mdl[sel ? 3 : 1]);
        sel = !sel;
      end
      step();
    end
    lite_ar_valid = 0; lite_r_ready = 1;
    for (int i = 0; i < 4 && q.size() != 0; i++) begin
      @(negedge clk);
      chk("strm_drain_data", lite_r_data, q[0]);
      if (lite_r_valid) void'(q.pop_front());
      step();
    end
    lite_r_ready = 0;
    @(negedge clk);
    chk("strm_idle_r_valid", lite_r_valid, 0);
    step();

    // Randomised traffic against the register-array model.
    for (int n = 0; n < 60; n++) begin
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        id, usr;
      a = 8'($urandom_range(0, 47));
      id = 1'($urandom_range(0, 1));
      usr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(1, 15));
        do_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), id, usr, rsp, wrs);
        mdl_write(a, d, s);
        chk("rnd_b_resp", rsp, in_rng(a) ? 2'b00 : ERR);
        chk("rnd_reg_wr", wrs, in_rng(a) ? 8'(1 << (a >> 2)) : 8'h00);
        for (int k = 0; k < NREG; k++) chk("rnd_reg_q", reg_q[k*32 +: 32], mdl[k]);
      end else begin
        do_read(a, id, usr, int'($urandom_range(0, 3)), rd, rsp);
        chk("rnd_r_resp", rsp, in_rng(a) ? 2'b00 : ERR);
        chk("rnd_r_data", rd, in_rng(a) ? mdl[a >> 2] : 32'h0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "time limit");
  end

endmodule

`default_nettype wire
